xmit_pkt_gen: RTL and testbench
===============================

XMIT_PKT_GEN -- requirements
Module: xmit_pkt_gen

Interface
REQ-001 SHALL have parameter DATA_W, default 8: data beat width in bits.
REQ-002 SHALL have parameter LEN_W, default 12: width of the length field and of the beat counter.
REQ-003 SHALL have parameter NUM_W, default 16: width of the packet-count config and of the packet counter.
REQ-004 SHALL have parameter MARK_BEATS, default 4: number of head and tail marker beats per packet.
REQ-005 SHALL have parameter MARK_VAL, default all-ones: value of each marker beat.
REQ-006 SHALL have ports, clock and reset first:
 - clk_sys  in  1  system clock, single clock domain.
 - reset  in  1  asynchronous, active-high reset.
 - start  in  1  one-cycle request to begin a run.
 - abort  in  1  synchronous run cancel.
 - ready  in  1  sink accepts the current beat.
 - cfg_len  in  LEN_W  beats per packet.
 - cfg_num  in  NUM_W  packets per run.
 - cfg_gap  in  8  idle cycles between packets.
 - cfg_fill  in  1  body fill: 0 = zero, 1 = incrementing beat index (low DATA_W bits).
 - cfg_prio  in  2  priority mode: 0 = always low, 1 = always high, 2 = alternate starting low, 3 = alternate starting high.
 - f_data_in  out  DATA_W  data beat.
 - f_rec_data_valid  out  1  beat valid.
 - f_ctrl_in  out  2*LEN_W  control word.
 - f_rec_frame_valid  out  1  control word valid.
 - f_hi_priority  out  1  priority of the current packet.
 - busy  out  1  run in progress.
 - done  out  1  one-cycle end-of-run pulse.
 - err  out  1  one-cycle bad-config pulse.
 - pkt_count  out  NUM_W  packets fully accepted in the current/last run.

Function
REQ-007 SHALL implement FSM states IDLE, PKT, GAP.
REQ-008 SHALL sample all cfg_* inputs on the accepted start; later changes SHALL NOT affect the run.
REQ-009 In IDLE, start with cfg_len!=0 and cfg_num!=0 SHALL clear pkt_count, go to PKT and present beat 0 in the next cycle.
REQ-010 In IDLE, start with cfg_len==0 or cfg_num==0 SHALL pulse err for 1 cycle and stay IDLE.
REQ-011 start while busy SHALL be ignored, with no err.
REQ-012 In PKT, f_rec_data_valid SHALL be 1; a beat SHALL be accepted only when ready=1, and while ready=0 every output and counter SHALL hold.
REQ-013 Beat i (0..len-1) SHALL be MARK_VAL if i<MARK_BEATS or i>=len-MARK_BEATS; otherwise 0 when cfg_fill=0, else i[DATA_W-1:0].
REQ-014 If len<=2*MARK_BEATS, all beats SHALL be markers.
REQ-015 f_rec_frame_valid SHALL be 1 only on beat 0, held until that beat is accepted.
REQ-016 f_ctrl_in SHALL be {len,len} on beat 0 and 0 otherwise (len=64, LEN_W=12 gives 24'h040040).
REQ-017 f_hi_priority SHALL be constant for a whole packet; alternating modes SHALL toggle per packet.
REQ-018 On acceptance of beat len-1, pkt_count SHALL increment.
REQ-019 After beat len-1 is accepted:
 - if it was the last packet: go IDLE and pulse done in the same cycle busy falls;
 - else if gap=0: present beat 0 of the next packet in the next cycle;
 - else: go to GAP.
REQ-020 GAP SHALL hold valids low for exactly cfg_gap cycles, then go to PKT.
REQ-021 abort in any state SHALL go IDLE next cycle with valids low, no done, and pkt_count retained.
REQ-022 If abort and start coincide in IDLE, abort SHALL win.
REQ-023 The beat counter SHALL count 0..len-1 with no wrap; the fill index SHALL wrap modulo 2^DATA_W.
REQ-024 busy SHALL be 1 in PKT and GAP.

Reset
REQ-025 reset SHALL force IDLE asynchronously and clear every output to 0: f_data_in, f_ctrl_in, pkt_count, all valids, f_hi_priority, busy, done, err.
REQ-026 reset asserted mid-packet SHALL truncate the packet immediately, with no done pulse.

Verification
REQ-027 The bench SHALL cover these scenarios:
 - len=64, num=64, gap=0, prio=0, fill=0, ready=1 -> 4096 contiguous beats; each packet is FF x4, 00 x56, FF x4; f_ctrl_in=040040 on beats 0,64,...; f_hi_priority=0; done at end; pkt_count=64.
 - Same config with ready toggling pseudo-randomly -> identical accepted beat sequence; outputs stable while ready=0.
 - len=10, num=3, gap=5, prio=3, fill=1 -> beats FF x4, 04, 05, FF x4; 5 idle cycles between packets; priority 1,0,1.
 - len=6, num=1 -> six FF beats, ctrl 006006; start with cfg_num=0 -> err pulse, busy stays 0.
 - abort at beat 20 of packet 3 -> valids low next cycle, busy=0, done=0, pkt_count=2.
 - reset at beat 30 -> all outputs 0 asynchronously; a new start after reset runs cleanly.

Source files
------------

// File: rtl/xmit_pkt_gen_if.sv
// Beat stream between the packet generator and its sink.
// The generator drives data, control and valids. The sink returns ready.
interface xmit_pkt_gen_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned LEN_W  = 12
);
  logic [DATA_W-1:0]  f_data_in;
  logic               f_rec_data_valid;
  logic [2*LEN_W-1:0] f_ctrl_in;
  logic               f_rec_frame_valid;
  logic               f_hi_priority;
  logic               ready;

  modport master (
    output f_data_in, f_rec_data_valid, f_ctrl_in, f_rec_frame_valid, f_hi_priority,
    input  ready
  );

  modport slave (
    input  f_data_in, f_rec_data_valid, f_ctrl_in, f_rec_frame_valid, f_hi_priority,
    output ready
  );
endinterface

// File: rtl/xmit_pkt_gen.sv
// Packet-run generator. Each packet is framed by marker beats, with an optional indexed body.
// Packets of a run are separated by configurable idle gaps.
module xmit_pkt_gen #(
  parameter int unsigned        DATA_W     = 8,
  parameter int unsigned        LEN_W      = 12,
  parameter int unsigned        NUM_W      = 16,
  parameter int unsigned        MARK_BEATS = 4,
  parameter logic [DATA_W-1:0]  MARK_VAL   = '1
) (
  input  logic               clk_sys,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic [NUM_W-1:0]   cfg_num,
  input  logic [7:0]         cfg_gap,
  input  logic               cfg_fill,
  input  logic [1:0]         cfg_prio,
  xmit_pkt_gen_if.master     bus,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [NUM_W-1:0]   pkt_count
);

  localparam int unsigned        LW1    = LEN_W + 1;
  localparam logic [LEN_W:0]     MARK_L = LW1'(MARK_BEATS);

  typedef enum logic [1:0] {IDLE, PKT, GAP} state_t;

  state_t               state_q, state_d;
  logic [LEN_W-1:0]     beat_q, beat_d, len_q, len_d;
  logic [NUM_W-1:0]     num_q, num_d, cnt_d;
  logic [7:0]           gapc_q, gapc_d, gcnt_q, gcnt_d;
  logic                 fill_q, fill_d, alt_q, alt_d, hi_d;
  logic                 done_d, err_d, present;
  logic [LEN_W-1:0]     pidx, plen;
  logic                 pfill;

  // Marker beats sit at both ends; the extended compare avoids len < MARK_BEATS underflow
  function automatic logic [DATA_W-1:0] beat_word(input logic [LEN_W-1:0] idx,
                                                  input logic [LEN_W-1:0] len,
                                                  input logic             fill);
    logic [LEN_W:0] ix;
    ix = {1'b0, idx};
    if (ix < MARK_L || ix + MARK_L >= {1'b0, len}) beat_word = MARK_VAL;
    else if (fill)                                  beat_word = DATA_W'(idx);
    else                                            beat_word = '0;
  endfunction

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    len_d   = len_q;
    num_d   = num_q;
    gapc_d  = gapc_q;
    gcnt_d  = gcnt_q;
    fill_d  = fill_q;
    alt_d   = alt_q;
    hi_d    = bus.f_hi_priority;
    cnt_d   = pkt_count;
    done_d  = 1'b0;
    err_d   = 1'b0;
    present = 1'b0;
    pidx    = beat_q;
    plen    = len_q;
    pfill   = fill_q;

    if (abort) begin
      state_d = IDLE;
      hi_d    = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            if (cfg_len == '0 || cfg_num == '0) begin
              err_d = 1'b1;
            end else begin
              state_d = PKT;
              len_d   = cfg_len;
              num_d   = cfg_num;
              gapc_d  = cfg_gap;
              fill_d  = cfg_fill;
              alt_d   = cfg_prio[1];
              hi_d    = cfg_prio[0];
              cnt_d   = '0;
              beat_d  = '0;
              present = 1'b1;
              pidx    = '0;
              plen    = cfg_len;
              pfill   = cfg_fill;
            end
          end
        end
        PKT: begin
          present = 1'b1;
          if (bus.ready) begin
            if (beat_q == len_q - LEN_W'(1)) begin
              cnt_d  = pkt_count + NUM_W'(1);
              beat_d = '0;
              pidx   = '0;
              if (cnt_d == num_q) begin
                state_d = IDLE;
                done_d  = 1'b1;
                present = 1'b0;
                hi_d    = 1'b0;
              end else begin
                hi_d = bus.f_hi_priority ^ alt_q;
                if (gapc_q != 8'd0) begin
                  state_d = GAP;
                  gcnt_d  = gapc_q;
                  present = 1'b0;
                end
              end
            end else begin
              beat_d = beat_q + LEN_W'(1);
              pidx   = beat_q + LEN_W'(1);
            end
          end
        end
        GAP: begin
          if (gcnt_q == 8'd1) begin
            state_d = PKT;
            present = 1'b1;
            pidx    = '0;
          end else begin
            gcnt_d = gcnt_q - 8'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q               <= IDLE;
      beat_q                <= '0;
      len_q                 <= '0;
      num_q                 <= '0;
      gapc_q                <= '0;
      gcnt_q                <= '0;
      fill_q                <= 1'b0;
      alt_q                 <= 1'b0;
      pkt_count             <= '0;
      busy                  <= 1'b0;
      done                  <= 1'b0;
      err                   <= 1'b0;
      bus.f_data_in         <= '0;
      bus.f_rec_data_valid  <= 1'b0;
      bus.f_ctrl_in         <= '0;
      bus.f_rec_frame_valid <= 1'b0;
      bus.f_hi_priority     <= 1'b0;
    end else begin
      state_q               <= state_d;
      beat_q                <= beat_d;
      len_q                 <= len_d;
      num_q                 <= num_d;
      gapc_q                <= gapc_d;
      gcnt_q                <= gcnt_d;
      fill_q                <= fill_d;
      alt_q                 <= alt_d;
      pkt_count             <= cnt_d;
      busy                  <= (state_d != IDLE);
      done                  <= done_d;
      err                   <= err_d;
      bus.f_data_in         <= present ? beat_word(pidx, plen, pfill) : '0;
      bus.f_rec_data_valid  <= present;
      bus.f_ctrl_in         <= (present && pidx == '0) ? {plen, plen} : '0;
      bus.f_rec_frame_valid <= present && pidx == '0;
      bus.f_hi_priority     <= hi_d;
    end
  end

endmodule

// File: tb/tb_xmit_pkt_gen.sv
// Randomized bench for xmit_pkt_gen against a per-run queue model of the expected beat stream.
module tb_xmit_pkt_gen;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        start, abort;
  logic [11:0] cfg_len;
  logic [15:0] cfg_num;
  logic [7:0]  cfg_gap;
  logic        cfg_fill;
  logic [1:0]  cfg_prio;
  logic        busy, done, err;
  logic [15:0] pkt_count;

  xmit_pkt_gen_if #(.DATA_W(8), .LEN_W(12)) bus ();

  xmit_pkt_gen dut (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .start     (start),
    .abort     (abort),
    .cfg_len   (cfg_len),
    .cfg_num   (cfg_num),
    .cfg_gap   (cfg_gap),
    .cfg_fill  (cfg_fill),
    .cfg_prio  (cfg_prio),
    .bus       (bus),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .pkt_count (pkt_count)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    logic [7:0]  data;
    logic [23:0] ctrl;
    logic        frame;
    logic        hi;
    int          pkt;
    logic        last;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cur_num = 0;
  int   cur_gap = 0;
  int   idle_run = 0;
  int   done_cnt = 0;
  bit   gap_pending = 0;
  bit   rnd_ready = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected accepted-beat stream of one whole run, built from the packet rules
  task automatic load_model(input int len, input int num, input int fill, input int prio);
    exp_q.delete();
    for (int p = 0; p < num; p++) begin
      logic h;
      case (prio)
        0:       h = 1'b0;
        1:       h = 1'b1;
        2:       h = (p % 2 == 1);
        default: h = (p % 2 == 0);
      endcase
      for (int i = 0; i < len; i++) begin
        exp_t e;
        if (i < 4 || i >= len - 4) e.data = 8'hFF;
        else                       e.data = fill != 0 ? 8'(i % 256) : 8'h00;
        e.frame = (i == 0);
        e.ctrl  = (i == 0) ? {12'(len), 12'(len)} : 24'h0;
        e.hi    = h;
        e.pkt   = p;
        e.last  = (i == len - 1);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic start_run(input int len, input int num, input int gap, input int fill, input int prio);
    load_model(len, num, fill, prio);
    cur_num     = num;
    cur_gap     = gap;
    gap_pending = 0;
    idle_run    = 0;
    @(posedge clk_sys); #1;
    cfg_len  = 12'(len);
    cfg_num  = 16'(num);
    cfg_gap  = 8'(gap);
    cfg_fill = 1'(fill);
    cfg_prio = 2'(prio);
    start    = 1'b1;
    @(posedge clk_sys); #1;
    start    = 1'b0;
    // Scramble the config to show the run only uses the values captured at start
    cfg_len  = 12'($urandom);
    cfg_num  = 16'($urandom);
    cfg_gap  = 8'($urandom);
    cfg_fill = 1'($urandom);
    cfg_prio = 2'($urandom);
  endtask

  task automatic wait_done(input int budget);
    int base;
    int n;
    base = done_cnt;
    n = 0;
    while (done_cnt == base && n < budget) begin
      @(posedge clk_sys);
      n++;
    end
    chk("done_timeout", 64'(done_cnt != base), 64'(1));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_data"},  64'(bus.f_data_in), 64'(0));
    chk({tag, "_dval"},  64'(bus.f_rec_data_valid), 64'(0));
    chk({tag, "_ctrl"},  64'(bus.f_ctrl_in), 64'(0));
    chk({tag, "_fval"},  64'(bus.f_rec_frame_valid), 64'(0));
    chk({tag, "_hi"},    64'(bus.f_hi_priority), 64'(0));
    chk({tag, "_busy"},  64'(busy), 64'(0));
    chk({tag, "_done"},  64'(done), 64'(0));
    chk({tag, "_err"},   64'(err), 64'(0));
    chk({tag, "_count"}, 64'(pkt_count), 64'(0));
  endtask

  // Ready driver: held high, or a coin flip each cycle
  initial begin
    bus.ready = 1'b1;
    forever begin
      @(posedge clk_sys); #1;
      bus.ready = rnd_ready ? 1'($urandom) : 1'b1;
    end
  end

  // Monitor: compares every presented beat with the model head, pops on acceptance
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_sys);
      if (!reset) begin
        if (bus.f_rec_data_valid) begin
          chk("busy_in_pkt", 64'(busy), 64'(1));
          if (gap_pending) begin
            chk("gap_len", 64'(idle_run), 64'(cur_gap));
            gap_pending = 0;
          end
          if (exp_q.size() == 0) begin
            chk("extra_beat", 64'(1), 64'(0));
          end else begin
            e = exp_q[0];
            chk("data",  64'(bus.f_data_in), 64'(e.data));
            chk("ctrl",  64'(bus.f_ctrl_in), 64'(e.ctrl));
            chk("frame", 64'(bus.f_rec_frame_valid), 64'(e.frame));
            chk("prio",  64'(bus.f_hi_priority), 64'(e.hi));
            if (bus.ready && !abort) begin
              void'(exp_q.pop_front());
              if (e.last && e.pkt != cur_num - 1) begin
                gap_pending = 1;
                idle_run    = 0;
              end
            end
          end
        end else begin
          chk("frame_without_data", 64'(bus.f_rec_frame_valid), 64'(0));
          if (busy) idle_run++;
        end
        if (done) begin
          done_cnt++;
          chk("done_busy", 64'(busy), 64'(0));
          chk("done_count", 64'(pkt_count), 64'(cur_num));
          chk("done_left", 64'(exp_q.size()), 64'(0));
        end
      end
    end
  end

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    abort    = 1'b0;
    cfg_len  = '0;
    cfg_num  = '0;
    cfg_gap  = '0;
    cfg_fill = 1'b0;
    cfg_prio = '0;
    #1;
    chk_all_zero("rst");
    #20;
    @(posedge clk_sys); #1;
    reset = 1'b0;

    // Long contiguous run, ready held high
    start_run(64, 64, 0, 0, 0);
    wait_done(10000);

    // Same run with random backpressure
    rnd_ready = 1;
    start_run(64, 64, 0, 0, 0);
    wait_done(30000);
    rnd_ready = 0;

    // Gapped, indexed, alternating-priority run; a start mid-run must be ignored
    start_run(10, 3, 5, 1, 3);
    repeat (3) @(posedge clk_sys);
    #1;
    cfg_len = 12'd5;
    cfg_num = 16'd0;
    start   = 1'b1;
    @(posedge clk_sys); #1;
    start = 1'b0;
    chk("busy_start_err", 64'(err), 64'(0));
    chk("busy_start_busy", 64'(busy), 64'(1));
    wait_done(1000);

    // Short all-marker packet
    start_run(6, 1, 0, 0, 0);
    wait_done(100);

    // Bad config start
    @(posedge clk_sys); #1;
    cfg_len = 12'd5;
    cfg_num = 16'd0;
    start   = 1'b1;
    @(posedge clk_sys); #1;
    start = 1'b0;
    chk("cfg_err_pulse", 64'(err), 64'(1));
    chk("cfg_err_busy", 64'(busy), 64'(0));
    chk("cfg_err_dval", 64'(bus.f_rec_data_valid), 64'(0));
    @(posedge clk_sys); #1;
    chk("cfg_err_clear", 64'(err), 64'(0));
    chk("cfg_err_busy2", 64'(busy), 64'(0));

    // Abort while beat 20 of the third packet is presented
    start_run(64, 8, 0, 0, 1);
    repeat (148) @(posedge clk_sys);
    #1;
    abort = 1'b1;
    @(posedge clk_sys); #1;
    abort = 1'b0;
    chk("abort_dval", 64'(bus.f_rec_data_valid), 64'(0));
    chk("abort_fval", 64'(bus.f_rec_frame_valid), 64'(0));
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_done", 64'(done), 64'(0));
    chk("abort_count", 64'(pkt_count), 64'(2));
    load_model(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_sys); #1;
      chk("abort_no_done", 64'(done), 64'(0));
      chk("abort_hold_count", 64'(pkt_count), 64'(2));
    end

    // Abort coinciding with start in idle
    @(posedge clk_sys); #1;
    cfg_len = 12'd8;
    cfg_num = 16'd1;
    start   = 1'b1;
    abort   = 1'b1;
    @(posedge clk_sys); #1;
    start = 1'b0;
    abort = 1'b0;
    chk("abort_wins_busy", 64'(busy), 64'(0));
    chk("abort_wins_dval", 64'(bus.f_rec_data_valid), 64'(0));

    // Asynchronous reset mid-packet, then a clean run
    start_run(64, 4, 0, 0, 1);
    repeat (30) @(posedge clk_sys);
    #3;
    reset = 1'b1;
    #1;
    chk_all_zero("midrst");
    load_model(0, 0, 0, 0);
    @(posedge clk_sys); #1;
    reset = 1'b0;
    start_run(10, 2, 1, 1, 2);
    wait_done(500);

    repeat (3) @(posedge clk_sys);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
